// File: rtl/day_12_pkg.sv
// Shared types and constants for the region-line transmitter:
// parser state encoding, ASCII byte codes and the default shape count.
package day_12_pkg;

  localparam int NUM_SHAPES_DEF = 6;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_X     = 8'h78;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    S_W,
    S_H,
    S_CNT,
    S_SKIP,
    S_SEND
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/day_12_region_tx_if.sv
// Byte-stream input and word-stream output of the region transmitter.
// slave is the transmitter's view, master is the view of whatever drives it.
interface day_12_region_tx_if;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/day_12_dec_acc.sv
// Saturating decimal accumulator: value = value*10 + digit, clamped at 255.
// has_digit remembers whether any digit arrived since the last clear.
module day_12_dec_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] digit,
  output logic [7:0] value,
  output logic       has_digit
);

  logic [11:0] sum;

  // Widened next value; 255*10+9 still fits in 12 bits so no wrap before the clamp
  always_comb begin
    sum = 12'(value) * 12'd10 + 12'(digit);
  end

  // Clear wins over a digit so a field boundary always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value     <= 8'd0;
      has_digit <= 1'b0;
    end else if (clr) begin
      value     <= 8'd0;
      has_digit <= 1'b0;
    end else if (en) begin
      value     <= (sum > 12'd255) ? 8'hFF : sum[7:0];
      has_digit <= 1'b1;
    end
  end

endmodule

// File: rtl/day_12_region_tx.sv
// Parses "<W>x<H>: c0 c1 ... \n" region lines and emits one frame per line:
// a dims word followed by NUM_SHAPES count words, the last one flagged.
module day_12_region_tx
  import day_12_pkg::*;
#(
  parameter int NUM_SHAPES = NUM_SHAPES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  day_12_region_tx_if.slave   bus,
  output logic                err,
  output logic [CNT_W-1:0]    lines_sent
);

  localparam int IDX_W = $clog2(NUM_SHAPES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SHAPES);

  state_t           state, state_next;
  logic [7:0]       w_val, h_val;
  logic [7:0]       counts [NUM_SHAPES];
  logic [IDX_W-1:0] idx, widx;
  logic [7:0]       in_byte;
  logic [7:0]       acc_val;
  logic             acc_has;
  logic             fire, word_fire, frame_done;
  logic             acc_clr, acc_en, lat_w, lat_h, lat_cnt, idx_clr;
  logic             err_next, start_send, bad;

  assign in_byte      = bus.s_tdata;
  assign bus.s_tready = !rst && (state != S_SEND);
  assign fire         = bus.s_tvalid && bus.s_tready;
  assign word_fire    = bus.m_tvalid && bus.m_tready;
  assign frame_done   = word_fire && (widx == IDX_LAST);

  day_12_dec_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .en        (acc_en),
    .digit     (in_byte[3:0]),
    .value     (acc_val),
    .has_digit (acc_has)
  );

  // Parser state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_W;
    else     state <= state_next;
  end

  // Next-state and datapath strobes; '\r' is invisible to every parse state
  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    lat_w      = 1'b0;
    lat_h      = 1'b0;
    lat_cnt    = 1'b0;
    idx_clr    = 1'b0;
    err_next   = 1'b0;
    start_send = 1'b0;
    bad        = 1'b0;
    if (state == S_SEND) begin
      if (frame_done) state_next = S_W;
    end else if (fire && (in_byte != CH_CR)) begin
      case (state)
        S_W: begin
          if (is_digit(in_byte)) acc_en = 1'b1;
          else if ((in_byte == CH_X) && acc_has) begin
            lat_w = 1'b1; acc_clr = 1'b1; state_next = S_H;
          end else if ((in_byte == CH_LF) && !acc_has) acc_clr = 1'b1;
          else bad = 1'b1;
        end
        S_H: begin
          if (is_digit(in_byte)) acc_en = 1'b1;
          else if ((in_byte == CH_COLON) && acc_has) begin
            lat_h = 1'b1; acc_clr = 1'b1; idx_clr = 1'b1; state_next = S_CNT;
          end else bad = 1'b1;
        end
        S_CNT: begin
          if (is_digit(in_byte)) begin
            if (idx == IDX_LAST) bad = 1'b1;
            else acc_en = 1'b1;
          end else if (in_byte == CH_SPACE) begin
            // Only a space that closes a number consumes a slot
            if (acc_has) begin lat_cnt = 1'b1; acc_clr = 1'b1; end
          end else if (in_byte == CH_LF) begin
            lat_cnt = acc_has;
            acc_clr = 1'b1;
            if ((idx + IDX_W'(acc_has)) == IDX_LAST) begin
              start_send = 1'b1; state_next = S_SEND;
            end else begin
              err_next = 1'b1; state_next = S_W;
            end
          end
        end
        S_SKIP: begin
          if (in_byte == CH_LF) begin acc_clr = 1'b1; state_next = S_W; end
        end
        default: ;
      endcase
      // A bad '\n' already ends its line, so skipping would swallow the next one
      if (bad) begin
        err_next   = 1'b1;
        acc_clr    = 1'b1;
        state_next = (in_byte == CH_LF) ? S_W : S_SKIP;
      end
    end
  end

  // Dimension latches, field index and the registered error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_val <= 8'd0;
      h_val <= 8'd0;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      if (lat_w) w_val <= acc_val;
      if (lat_h) h_val <= acc_val;
      if (idx_clr)      idx <= '0;
      else if (lat_cnt) idx <= idx + IDX_W'(1);
      err <= err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SHAPES; gi++) begin : g_cnt
      // Count slot gi captures the pending field when the index points at it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) counts[gi] <= 8'd0;
        else if (lat_cnt && (idx == IDX_W'(gi))) counts[gi] <= acc_val;
      end
    end
  endgenerate

  // Output word sequencer: registered valid/data/last, advanced only on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= 32'd0;
      bus.m_tlast  <= 1'b0;
      widx         <= '0;
      lines_sent   <= '0;
    end else if (start_send) begin
      bus.m_tvalid <= 1'b1;
      bus.m_tdata  <= {16'd0, w_val, h_val};
      bus.m_tlast  <= 1'b0;
      widx         <= '0;
    end else if (word_fire) begin
      if (widx == IDX_LAST) begin
        bus.m_tvalid <= 1'b0;
        bus.m_tlast  <= 1'b0;
        lines_sent   <= lines_sent + CNT_W'(1);
      end else begin
        widx         <= widx + IDX_W'(1);
        bus.m_tdata  <= {24'd0, counts[widx]};
        bus.m_tlast  <= ((widx + IDX_W'(1)) == IDX_LAST);
      end
    end
  end

endmodule

// File: doc/day_12_region_tx.md
DAY_12_REGION_TX -- requirements
Module: day_12_region_tx

Interface
REQ-001 Parameter NUM_SHAPES, default 6, number of count fields per region line and count words per frame.
REQ-002 Parameter CNT_W, default 16, width of lines_sent.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_tvalid  input  1  ASCII byte valid.
REQ-006 s_tready  output  1  byte accepted when s_tvalid&&s_tready.
REQ-007 s_tdata  input  8  ASCII byte of puzzle region text.
REQ-008 m_tvalid  output  1  output word valid.
REQ-009 m_tready  input  1  downstream solver accepts word.
REQ-010 m_tdata  output  32  dims or count word.
REQ-011 m_tlast  output  1  high on final count word of a frame.
REQ-012 err  output  1  one-cycle pulse per malformed line.
REQ-013 lines_sent  output  CNT_W  count of complete frames transmitted, wraps.

Function
REQ-014 Input grammar per line SHALL be "<W>x<H>:" then NUM_SHAPES space-separated decimals then '\n'; '\r' is ignored in every parse state.
REQ-015 Decimal fields SHALL accumulate as acc*10+digit, saturating at 255 (8-bit result).
REQ-016 Frame SHALL be NUM_SHAPES+1 words: word0 = {16'b0, W[7:0], H[7:0]}, word k = {24'b0, count[k-1]}, m_tlast only on word NUM_SHAPES.
REQ-017 States: S_W, S_H, S_CNT, S_SKIP, S_SEND; s_tready=1 in every state except S_SEND.
REQ-018 S_W: digit accumulates; 'x' with >=1 digit latches W -> S_H; '\n' with no digits stays (blank line); any other byte -> err, S_SKIP.
REQ-019 S_H: digit accumulates; ':' with >=1 digit latches H, clears index -> S_CNT; any other byte -> err, S_SKIP.
REQ-020 S_CNT: ' ' latches pending value into count[index] and increments index, else ignored (multiple spaces legal); a digit when index==NUM_SHAPES -> err, S_SKIP; '\n' latches pending value, then index==NUM_SHAPES -> S_SEND, otherwise err -> S_W.
REQ-021 S_SKIP: discard bytes until '\n', then S_W with accumulators cleared.
REQ-022 S_SEND: m_tvalid asserted the cycle after the terminating '\n' is accepted; word index advances only on m_tvalid&&m_tready; m_tdata/m_tlast held stable while m_tvalid&&!m_tready.
REQ-023 Handshake on last word: m_tvalid drops next cycle, lines_sent increments, state -> S_W, s_tready=1 in that same cycle.
REQ-024 m_tvalid SHALL never depend combinationally on m_tready; outputs registered.

Reset
REQ-025 On rst: state S_W, m_tvalid=0, m_tlast=0, m_tdata=0, err=0, lines_sent=0, accumulators/index/count registers 0; s_tready=0 while rst is asserted, 1 the first cycle after release.
REQ-026 rst asserted mid-frame (any state, including S_SEND with m_tvalid high) SHALL abort immediately; no partial frame resumes after release.

Structure
REQ-027 Shared package day_12_pkg SHALL hold the state enum, ASCII constants ('0','9','x',':',' ','\n','\r') and the NUM_SHAPES default.
REQ-028 One sub-module day_12_dec_acc SHALL implement the saturating decimal accumulator (clear, digit-enable, 8-bit value, has_digit flag).

Verification
REQ-029 "12x5: 1 0 1 0 2 2\n", m_tready=1 -> 0x00000C05,1,0,1,0,2,2; tlast on 7th word only; lines_sent=1.
REQ-030 Same line with m_tready toggling 1-0 every cycle -> identical 7 words, data stable during stalls, s_tready=0 throughout S_SEND.
REQ-031 "300x4:  0 0 0 0 0 999\n" -> word0 0x0000FF04, last count 0xFF, double space accepted.
REQ-032 "4x4 0 0 0 0 0 0\n" then "4x4: 1 0 0 0 0 0\n" -> one err pulse, only second frame emitted (0x00000404,1,0,0,0,0,0).
REQ-033 "5x5: 1 2 3\n" and "5x5: 1 2 3 4 5 6 7\n" -> err pulse each, no output, lines_sent unchanged.
REQ-034 rst during word 3 of a frame -> m_tvalid=0 asynchronously; after release next valid line transmits a full 7-word frame, lines_sent=1.
